// File: rtl/regbk_initiator.sv
// regbk_initiator: buffers register read/write commands in a small FIFO and issues them one
// at a time over the regbank req/ack interface, returning read data or a write completion
// on a response handshake.
// Optional feature: define REGBK_INIT_TIMEOUT_EN to build the request timeout/abort path.

module regbk_initiator #(
    parameter int unsigned ADDR_BW        = 7,
    parameter int unsigned DATA_BW        = 8,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_BW-1:0] cmd_addr,
    input  logic [DATA_BW-1:0] cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_BW-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               reg_req,
    output logic               reg_write,
    output logic [ADDR_BW-1:0] reg_addr,
    output logic [DATA_BW-1:0] reg_wdata,
    input  logic               reg_ack,
    input  logic [DATA_BW-1:0] reg_rdata
);

    localparam int unsigned PtrW = $clog2(CMD_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = 1 + ADDR_BW + DATA_BW;

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e state_q, state_d;

    logic [EntW-1:0]    fifo_mem [CMD_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q;
    logic               fifo_full, fifo_empty, push, pop;
    logic               head_write;
    logic [ADDR_BW-1:0] head_addr;
    logic [DATA_BW-1:0] head_wdata;
    logic               timeout;

    logic               reg_req_q, reg_req_d;
    logic               reg_write_q, reg_write_d;
    logic [ADDR_BW-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_BW-1:0] reg_wdata_q, reg_wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_BW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    assign fifo_full  = (count_q == CntW'(CMD_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = !rst && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    // Only IDLE pops, so a freshly pushed command is seen one cycle later (no bypass).
    assign pop        = (state_q == StIdle) && !fifo_empty;

    assign {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr_q];

    // FIFO storage; entries need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef REGBK_INIT_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WaitW-1:0] wait_cnt_q;

    // Counts REQ cycles of the current access, saturating; cleared outside REQ.
    always_ff @(posedge clk) begin
        if (rst || state_q != StReq) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != WaitW'(TIMEOUT_CYCLES)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Fires in the final allowed REQ cycle; an ack in that cycle still wins.
    assign timeout = (state_q == StReq) && (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty)          state_d = StReq;
            StReq:   if (reg_ack || timeout)   state_d = StRsp;
            StRsp:   if (rsp_ready)            state_d = StIdle;
            default:                           state_d = StIdle;
        endcase
    end

    // FSM outputs: next values of the registered request and response signals.
    always_comb begin
        reg_req_d   = (state_d == StReq);
        rsp_valid_d = (state_d == StRsp);
        reg_write_d = reg_write_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (pop) begin
            reg_write_d = head_write;
            reg_addr_d  = head_addr;
            reg_wdata_d = head_wdata;
        end
        if (state_q == StReq && (reg_ack || timeout)) begin
            rsp_rdata_d = (reg_ack && !reg_write_q) ? reg_rdata : '0;
            rsp_err_d   = !reg_ack;
        end
    end

    // Output registers; reset drops any in-flight access without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_req_q   <= 1'b0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            reg_req_q   <= reg_req_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign reg_req   = reg_req_q;
    assign reg_write = reg_write_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_regbk_initiator.sv
// Bench for regbk_initiator: table of command vectors plus hand-written timing sequences.
// A regbank responder model acks with per-command latency; request and response
// scoreboards check ordering, contents and stability.

module tb_regbk_initiator;

    typedef struct {
        logic       w;
        logic [6:0] a;
        logic [7:0] d;
        int         lat;       // ack in this REQ cycle (1 = zero-wait), -1 = never
        logic [7:0] ack_data;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    typedef struct {
        int         lat;
        logic [7:0] data;
    } ack_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       reg_req;
    logic       reg_write;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_ack = 1'b0;
    logic [7:0] reg_rdata = '0;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;

    logic [15:0] exp_req_q [$];
    ack_t        ack_q [$];
    logic [8:0]  exp_rsp_q [$];
    int          rise_q [$];

    regbk_initiator dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .reg_req   (reg_req),
        .reg_write (reg_write),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void fail(string name);
        check_cnt++;
        $display("FAIL %s: got an event with nothing expected (cycle %0d)", name, cyc);
    endfunction

    function automatic vec_t mk(logic w, logic [6:0] a, logic [7:0] d, int lat,
                                logic [7:0] ackd, logic [7:0] expd, logic experr);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.lat = lat;
        v.ack_data = ackd; v.exp_rdata = expd; v.exp_err = experr;
        return v;
    endfunction

    // Regbank responder model plus request scoreboard and request stability check.
    ack_t        cur_ack;
    logic [15:0] cur_req;
    bit          resp_active = 1'b0;
    int          resp_cnt = 0;
    always @(negedge clk) begin
        reg_ack   = 1'b0;
        reg_rdata = 8'($urandom);
        if (rst || !reg_req) begin
            resp_active = 1'b0;
        end else begin
            if (!resp_active) begin
                resp_active = 1'b1;
                resp_cnt    = 1;
                rise_q.push_back(cyc);
                cur_req = {reg_write, reg_addr, reg_wdata};
                if (ack_q.size() > 0) cur_ack = ack_q.pop_front();
                else cur_ack = '{lat: -1, data: 8'h00};
                if (exp_req_q.size() > 0) chk("req_cmd", {reg_write, reg_addr, reg_wdata},
                                              exp_req_q.pop_front());
                else fail("unexpected_req");
            end else begin
                resp_cnt++;
                chk("req_stable", {reg_write, reg_addr, reg_wdata}, cur_req);
            end
            if (cur_ack.lat == resp_cnt) begin
                reg_ack   = 1'b1;
                reg_rdata = cur_ack.data;
            end
        end
    end

    // Response scoreboard plus hold-until-handshake check.
    bit         mon_prev_valid = 1'b0;
    bit         mon_prev_hs = 1'b0;
    logic [8:0] mon_prev_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            mon_prev_valid = 1'b0;
        end else begin
            if (mon_prev_valid && !mon_prev_hs) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_data", {rsp_err, rsp_rdata}, mon_prev_data);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() > 0) chk("rsp_data", {rsp_err, rsp_rdata},
                                              exp_rsp_q.pop_front());
                else fail("unexpected_rsp");
            end
            mon_prev_valid = rsp_valid;
            mon_prev_hs    = rsp_valid && rsp_ready;
            mon_prev_data  = {rsp_err, rsp_rdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command; leaves cmd_valid high so consecutive calls push back-to-back.
    task automatic push(input vec_t v);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = v.w;
        cmd_addr  = v.a;
        cmd_wdata = v.d;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        chk("push_ready", cmd_ready, 1);
        if (cmd_ready) begin
            exp_req_q.push_back({v.w, v.a, v.d});
            ack_q.push_back('{lat: v.lat, data: v.ack_data});
            exp_rsp_q.push_back({v.exp_err, v.exp_rdata});
            tick();
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_sig(input bit sel_rsp, input int budget, input string name,
                            output int t);
        int n = 0;
        while ((sel_rsp ? rsp_valid : reg_req) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        t = cyc;
        chk(name, sel_rsp ? rsp_valid : reg_req, 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_rsp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_outstanding", exp_rsp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs [8];
    int   t0, t1, k;

    initial begin
        vecs[0] = mk(1'b1, 7'h00, 8'h11, 1, 8'h9E, 8'h00, 1'b0);
        vecs[1] = mk(1'b1, 7'h01, 8'h22, 1, 8'h9E, 8'h00, 1'b0);
        vecs[2] = mk(1'b1, 7'h02, 8'h33, 1, 8'h9E, 8'h00, 1'b0);
        vecs[3] = mk(1'b1, 7'h03, 8'h44, 1, 8'h9E, 8'h00, 1'b0);
        vecs[4] = mk(1'b0, 7'h7F, 8'h00, 2, 8'hFF, 8'hFF, 1'b0);
        vecs[5] = mk(1'b0, 7'h00, 8'hEE, 1, 8'h00, 8'h00, 1'b0);
        vecs[6] = mk(1'b1, 7'h55, 8'hAA, 5, 8'h99, 8'h00, 1'b0);
        vecs[7] = mk(1'b0, 7'h2A, 8'h00, 4, 8'h5C, 8'h5C, 1'b0);

        // Reset state.
        tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_outputs", {reg_req, reg_write, reg_addr, reg_wdata, rsp_valid, rsp_rdata,
                            rsp_err}, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Single read, ack in the 3rd REQ cycle: cycle-exact latencies.
        push(mk(1'b0, 7'h05, 8'h00, 3, 8'hA7, 8'hA7, 1'b0));
        cmd_valid = 1'b0;
        chk("rd_n1_req", reg_req, 0);
        tick();
        chk("rd_n2_req", reg_req, 1);
        chk("rd_n2_addr", reg_addr, 7'h05);
        tick();
        tick();
        chk("rd_n4_req", reg_req, 1);
        chk("rd_n4_valid", rsp_valid, 0);
        tick();
        chk("rd_n5_req", reg_req, 0);
        chk("rd_n5_valid", rsp_valid, 1);
        chk("rd_n5_rsp", {rsp_err, rsp_rdata}, 9'h0A7);
        tick();

        // Table of commands pushed back-to-back with rsp_ready held high.
        for (int i = 0; i < 8; i++) push(vecs[i]);
        cmd_valid = 1'b0;
        drain(400);

        // Response backpressure with the FIFO filled behind the stalled response.
        rsp_ready = 1'b0;
        push(mk(1'b0, 7'h66, 8'h00, 1, 8'hC3, 8'hC3, 1'b0));
        cmd_valid = 1'b0;
        wait_sig(1'b1, 20, "bp_rsp_seen", t0);
        rise_q.delete();
        push(mk(1'b1, 7'h10, 8'h11, 1, 8'h01, 8'h00, 1'b0));
        push(mk(1'b1, 7'h11, 8'h22, 1, 8'h02, 8'h00, 1'b0));
        push(mk(1'b1, 7'h12, 8'h33, 1, 8'h03, 8'h00, 1'b0));
        push(mk(1'b1, 7'h13, 8'h44, 1, 8'h04, 8'h00, 1'b0));
        cmd_valid = 1'b0;
        chk("full_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < 6; i++) begin
            chk("bp_req_low", reg_req, 0);
            chk("bp_valid_held", rsp_valid, 1);
            tick();
        end
        k = cyc;
        rsp_ready = 1'b1;
        drain(100);
        chk("bb_req_count", rise_q.size(), 4);
        if (rise_q.size() > 0) chk("bb_first_req_gap", rise_q[0] - k, 2);
        for (int i = 1; i < rise_q.size(); i++) chk("bb_req_spacing", rise_q[i] - rise_q[i-1], 3);

`ifdef REGBK_INIT_TIMEOUT_EN
        // Timeout with no ack, then an ack in the final allowed cycle.
        push(mk(1'b0, 7'h21, 8'h00, -1, 8'h00, 8'h00, 1'b1));
        cmd_valid = 1'b0;
        wait_sig(1'b0, 20, "to_req_seen", t0);
        wait_sig(1'b1, 40, "to_rsp_seen", t1);
        chk("to_latency", t1 - t0, 16);
        chk("to_rsp", {rsp_err, rsp_rdata}, 9'h100);
        tick();
        push(mk(1'b0, 7'h22, 8'h00, 16, 8'h3C, 8'h3C, 1'b0));
        cmd_valid = 1'b0;
        wait_sig(1'b0, 20, "late_req_seen", t0);
        wait_sig(1'b1, 40, "late_rsp_seen", t1);
        chk("late_latency", t1 - t0, 16);
        chk("late_rsp", {rsp_err, rsp_rdata}, 9'h03C);
        tick();
`else
        // No timeout: request held for 100 cycles, then a late ack completes normally.
        push(mk(1'b0, 7'h33, 8'h00, 101, 8'h5A, 8'h5A, 1'b0));
        cmd_valid = 1'b0;
        wait_sig(1'b0, 20, "hold_req_seen", t0);
        for (int i = 0; i < 100; i++) begin
            chk("hold_req", {reg_req, rsp_valid, reg_addr}, {2'b10, 7'h33});
            tick();
        end
        wait_sig(1'b1, 5, "hold_rsp_seen", t1);
        chk("hold_latency", t1 - t0, 101);
        chk("hold_rsp", {rsp_err, rsp_rdata}, 9'h05A);
        tick();
`endif
        drain(50);

        // Reset mid-access with two commands queued.
        push(mk(1'b0, 7'h40, 8'h00, -1, 8'h00, 8'h00, 1'b0));
        cmd_valid = 1'b0;
        wait_sig(1'b0, 20, "rst_req_seen", t0);
        push(mk(1'b1, 7'h41, 8'h77, 1, 8'h00, 8'h00, 1'b0));
        push(mk(1'b0, 7'h42, 8'h00, 1, 8'h88, 8'h88, 1'b0));
        cmd_valid = 1'b0;
        chk("pre_rst_req", reg_req, 1);
        rst = 1'b1;
        exp_req_q.delete();
        ack_q.delete();
        exp_rsp_q.delete();
        #1;
        chk("in_rst_cmd_ready", cmd_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("after_rst", {reg_req, rsp_valid, cmd_ready}, 3'b001);
        for (int i = 0; i < 10; i++) begin
            chk("no_stale", {reg_req, rsp_valid}, 2'b00);
            tick();
        end
        push(mk(1'b0, 7'h44, 8'h00, 2, 8'h81, 8'h81, 1'b0));
        cmd_valid = 1'b0;
        drain(50);
        chk("final_req_q_empty", exp_req_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
